mdio_set: RTL and testbench
===========================

MDIO_SET -- requirements
Module: mdio_set

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'b00001, the target PHY address.
REQ-002 SHALL have parameter REG_ADDR, default 5'd0, the target PHY register address.
REQ-003 SHALL have parameter REG_DATA, default 16'h2100, the 16-bit value written.
REQ-004 SHALL have parameter MDC_DIV, default 10, the number of sys_clk cycles per MDC half-period.
REQ-005 SHALL have port sys_clk, input, 1 bit, the single system clock (50 MHz nominal).
REQ-006 SHALL have port sys_rst_n, input, 1 bit, a synchronous active-low reset sampled on the sys_clk rising edge.
REQ-007 SHALL have port mdio_set_start_flag, input, 1 bit, a write-transaction request sampled high on any sys_clk edge.
REQ-008 SHALL have port mdc, output, 1 bit, the MDIO management clock.
REQ-009 SHALL have port mdio, inout, 1 bit, management data driven by this block or released to high-Z.

Function
REQ-010 SHALL run a free-running divider: counter 0..MDC_DIV-1 on sys_clk; at count MDC_DIV-1 the counter wraps to 0 and mdc toggles; MDC period = 2*MDC_DIV sys_clk cycles (400 ns default).
REQ-011 SHALL define a "falling tick" as the sys_clk edge on which mdc toggles 1->0; all mdio changes SHALL occur only on falling ticks, so data is stable across each MDC rising edge.
REQ-012 SHALL implement states IDLE, PREAMBLE, FRAME, and DONE.
REQ-013 In IDLE, a sys_clk cycle with mdio_set_start_flag=1 SHALL latch a pending request; any further assertion while pending or busy SHALL be ignored (no queuing).
REQ-014 On the first falling tick with the request pending, the state SHALL become PREAMBLE, mdio SHALL be driven 1, and the pending request SHALL clear.
REQ-015 PREAMBLE SHALL drive mdio=1 for exactly 32 MDC periods, then enter FRAME on the next falling tick.
REQ-016 FRAME SHALL shift out MSB first, one bit per falling tick, the 32-bit word {2'b01 ST, 2'b01 OP write, PHY_ADDR, REG_ADDR, 2'b10 TA, REG_DATA}.
REQ-017 After the 32nd FRAME bit's period, on the next falling tick the state SHALL become DONE, mdio SHALL be released to high-Z, and the state SHALL return to IDLE on the following sys_clk cycle.
REQ-018 A complete transaction SHALL be 64 driven MDC periods (25.6 us default).
REQ-019 mdio SHALL be high-Z in IDLE and DONE and SHALL be driven only in PREAMBLE and FRAME.
REQ-020 The block SHALL never read mdio, since it is write-only.
REQ-021 A bit counter SHALL count 0..31 per phase and reset to 0 on each phase change.

Reset
REQ-022 While sys_rst_n=0 at a sys_clk edge: state=IDLE, divider counter=0, mdc=0, bit counter=0, pending request cleared, mdio high-Z.
REQ-023 Reset mid-transaction SHALL abort it immediately at that edge with no partial completion after release.
REQ-024 After release, the first mdc rising edge SHALL occur MDC_DIV cycles later and the first falling tick 2*MDC_DIV cycles later.

Verification
REQ-025 Reset 1 cycle, release, then 1-cycle start pulse -> mdio high-Z until the first falling tick, then 32 ones, then bits 0101_00001_00000_10_0010000100000000, then high-Z; mdc period 400 ns throughout.
REQ-026 Sample mdio on each mdc rising edge during the transaction -> 64 bits exactly match REQ-016 with a 32-ones preamble; no mdio transition within 1 sys_clk of any mdc rising edge.
REQ-027 Assert start again 5 us into a transaction -> the current frame is unaffected, and no second frame follows DONE.
REQ-028 Assert sys_rst_n=0 during FRAME -> mdio goes high-Z and mdc goes 0 on the same edge; no activity resumes without a new start.
REQ-029 Issue two starts separated by 30 us -> two identical back-to-back-spaced frames with mdio high-Z between them.
REQ-030 Override parameters to PHY_ADDR=5'h1F, REG_ADDR=5'h04, REG_DATA=16'h01E1 -> the frame carries those fields at the bit positions in REQ-016.

Source files
------------

// File: rtl/mdio_set.sv
// mdio_set: one-shot MDIO (clause 22) register write engine.
// A start request launches a 32-bit all-ones preamble followed by a single
// write frame {ST, OP, PHY_ADDR, REG_ADDR, TA, REG_DATA}, shifted out MSB first.
// MDC is derived from sys_clk. mdio only changes on the sys_clk edge where
// MDC falls, so the data is stable around every MDC rising edge.
// The block never samples mdio; it either drives the line or releases it.
module mdio_set #(
  parameter logic [4:0]  PHY_ADDR = 5'b00001,
  parameter logic [4:0]  REG_ADDR = 5'd0,
  parameter logic [15:0] REG_DATA = 16'h2100,
  parameter int          MDC_DIV  = 10
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic mdio_set_start_flag,
  output logic mdc,
  inout  wire  mdio
);

  localparam int CNT_W = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(MDC_DIV - 1);
  localparam logic [4:0] LAST_BIT = 5'd31;

  // Assemble the write frame: start, write opcode, addresses, turnaround, data.
  function automatic logic [31:0] build_frame(input logic [4:0]  phy,
                                              input logic [4:0]  rega,
                                              input logic [15:0] data);
    build_frame = {2'b01, 2'b01, phy, rega, 2'b10, data};
  endfunction

  localparam logic [31:0] FRAME_WORD = build_frame(PHY_ADDR, REG_ADDR, REG_DATA);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    FRAME    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic             pending;
  logic             mdio_oe;
  logic             mdio_out;
  logic [31:0]      shift_reg;
  logic             fall_tick;

  // The edge on which mdc is about to toggle from 1 to 0.
  assign fall_tick = (div_cnt == DIV_LAST) && mdc;

  // Free-running MDC divider; mdc toggles each time the counter wraps.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
      mdc     <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      mdc     <= ~mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Transaction sequencer: request latch, phase tracking and output enable.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      pending <= 1'b0;
      mdio_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mdio_oe <= 1'b0;
          if (fall_tick && pending) begin
            // A start seen on this same edge is ignored: we are now busy.
            state   <= PREAMBLE;
            mdio_oe <= 1'b1;
            pending <= 1'b0;
            bit_cnt <= 5'd0;
          end else if (mdio_set_start_flag) begin
            pending <= 1'b1;
          end
        end
        PREAMBLE: begin
          if (fall_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= FRAME;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        FRAME: begin
          if (fall_tick) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= DONE;
              mdio_oe <= 1'b0;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          mdio_oe <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mdio_oe <= 1'b0;
        end
      endcase
    end
  end

  // Serial data path; only meaningful while mdio_oe is set, so it needs no reset.
  always_ff @(posedge sys_clk) begin
    if (fall_tick) begin
      case (state)
        IDLE: begin
          mdio_out <= 1'b1;
        end
        PREAMBLE: begin
          if (bit_cnt == LAST_BIT) begin
            mdio_out  <= FRAME_WORD[31];
            shift_reg <= {FRAME_WORD[30:0], 1'b0};
          end else begin
            mdio_out  <= 1'b1;
          end
        end
        FRAME: begin
          mdio_out  <= shift_reg[31];
          shift_reg <= {shift_reg[30:0], 1'b0};
        end
        default: begin
          mdio_out <= mdio_out;
        end
      endcase
    end
  end

  assign mdio = mdio_oe ? mdio_out : 1'bz;

endmodule

// File: tb/tb_mdio_set.sv
// Directed bench for mdio_set. Each configuration is instantiated twice, one
// copy with a pull-up and one with a pull-down on mdio: the copies agree when
// the line is driven and disagree (1 vs 0) when it is released.
module tb_mdio_set;

  localparam int MDC_DIV = 10;
  localparam int PERIOD  = 2 * MDC_DIV;
  localparam logic [63:0] EXP_A = {32'hFFFF_FFFF, 32'h5082_2100};
  localparam logic [63:0] EXP_B = {32'hFFFF_FFFF, 32'h5F92_01E1};

  logic sys_clk;
  logic sys_rst_n;
  logic start_a;
  logic start_b;
  logic mdc_au, mdc_ad, mdc_bu, mdc_bd;
  wire  mdio_au, mdio_ad, mdio_bu, mdio_bd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pullup   (mdio_au);
  pulldown (mdio_ad);
  pullup   (mdio_bu);
  pulldown (mdio_bd);

  mdio_set u_dut_au (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
                     .mdio_set_start_flag(start_a), .mdc(mdc_au), .mdio(mdio_au));
  mdio_set u_dut_ad (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
                     .mdio_set_start_flag(start_a), .mdc(mdc_ad), .mdio(mdio_ad));
  mdio_set #(.PHY_ADDR(5'h1F), .REG_ADDR(5'h04), .REG_DATA(16'h01E1), .MDC_DIV(MDC_DIV))
    u_dut_bu (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
              .mdio_set_start_flag(start_b), .mdc(mdc_bu), .mdio(mdio_bu));
  mdio_set #(.PHY_ADDR(5'h1F), .REG_ADDR(5'h04), .REG_DATA(16'h01E1), .MDC_DIV(MDC_DIV))
    u_dut_bd (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
              .mdio_set_start_flag(start_b), .mdc(mdc_bd), .mdio(mdio_bd));

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Current mdc, driven flag and line value of one configuration.
  task automatic sample(input bit sel, output bit c, output bit d, output bit v);
    if (sel) begin
      c = mdc_bu; d = (mdio_bu == mdio_bd); v = mdio_bu;
    end else begin
      c = mdc_au; d = (mdio_au == mdio_ad); v = mdio_au;
    end
  endtask

  // Watch one configuration for ncyc cycles, collecting mdio at mdc rising edges.
  task automatic monitor(input bit sel, input int ncyc, output logic [63:0] bits,
                         output int nbits, output int drv, output int viol,
                         output int per_bad);
    bit c, d, v, pc, pd, pv, seen_rise;
    int since_rise;
    bits = '0; nbits = 0; drv = 0; viol = 0; per_bad = 0;
    seen_rise = 1'b0; since_rise = 0;
    sample(sel, pc, pd, pv);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge sys_clk);
      sample(sel, c, d, v);
      since_rise++;
      if (c && !pc) begin
        if (seen_rise && since_rise != PERIOD) per_bad++;
        seen_rise  = 1'b1;
        since_rise = 0;
        if (d) begin
          bits = {bits[62:0], v};
          nbits++;
        end
      end
      if (d) drv++;
      // Any drive start, release or value change must coincide with mdc falling.
      if ((d != pd || (d && pd && v != pv)) && !(pc && !c)) viol++;
      pc = c; pd = d; pv = v;
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask

  task automatic test_reset();
    bit c, d, v;
    int rise_at, fall_at;
    sys_rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    tick(2);
    sample(1'b0, c, d, v);
    chk_cnt++; if (c !== 1'b0) $display("FAIL reset_mdc: got %0b want 0", c); else pass_cnt++;
    chk_cnt++; if (d !== 1'b0) $display("FAIL reset_mdio_z: driven=%0b want 0", d); else pass_cnt++;
    sample(1'b1, c, d, v);
    chk_cnt++; if (d !== 1'b0) $display("FAIL reset_mdio_z_b: driven=%0b want 0", d); else pass_cnt++;
    sys_rst_n = 1'b1;
    rise_at = -1; fall_at = -1;
    for (int i = 1; i <= 4 * MDC_DIV; i++) begin
      @(negedge sys_clk);
      if (rise_at < 0 && mdc_au) rise_at = i;
      if (rise_at >= 0 && fall_at < 0 && !mdc_au) fall_at = i;
    end
    chk_cnt++; if (rise_at != MDC_DIV) $display("FAIL first_rise: got %0d want %0d", rise_at, MDC_DIV); else pass_cnt++;
    chk_cnt++; if (fall_at != PERIOD) $display("FAIL first_fall: got %0d want %0d", fall_at, PERIOD); else pass_cnt++;
    sample(1'b0, c, d, v);
    chk_cnt++; if (d !== 1'b0) $display("FAIL idle_mdio_z: driven=%0b want 0", d); else pass_cnt++;
  endtask

  task automatic test_frame();
    logic [63:0] bits; int nb, drv, viol, pb;
    bit c, d, v;
    fork
      monitor(1'b0, 1400, bits, nb, drv, viol, pb);
      pulse_a();
    join
    chk_cnt++; if (nb != 64) $display("FAIL frame_nbits: got %0d want 64", nb); else pass_cnt++;
    chk_cnt++; if (bits !== EXP_A) $display("FAIL frame_bits: got %h want %h", bits, EXP_A); else pass_cnt++;
    chk_cnt++; if (drv != 64 * PERIOD) $display("FAIL frame_drive_len: got %0d want %0d", drv, 64 * PERIOD); else pass_cnt++;
    chk_cnt++; if (viol != 0) $display("FAIL frame_timing: got %0d violations want 0", viol); else pass_cnt++;
    chk_cnt++; if (pb != 0) $display("FAIL frame_mdc_period: got %0d bad periods want 0", pb); else pass_cnt++;
    sample(1'b0, c, d, v);
    chk_cnt++; if (d !== 1'b0) $display("FAIL frame_release: driven=%0b want 0", d); else pass_cnt++;
  endtask

  task automatic test_restart_ignored();
    logic [63:0] bits; int nb, drv, viol, pb;
    fork
      monitor(1'b0, 3000, bits, nb, drv, viol, pb);
      begin
        pulse_a();
        tick(250);
        pulse_a();
      end
    join
    chk_cnt++; if (nb != 64) $display("FAIL restart_nbits: got %0d want 64", nb); else pass_cnt++;
    chk_cnt++; if (bits !== EXP_A) $display("FAIL restart_bits: got %h want %h", bits, EXP_A); else pass_cnt++;
    chk_cnt++; if (drv != 64 * PERIOD) $display("FAIL restart_drive_len: got %0d want %0d", drv, 64 * PERIOD); else pass_cnt++;
    chk_cnt++; if (viol != 0) $display("FAIL restart_timing: got %0d want 0", viol); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] bits; int nb, drv, viol, pb;
    for (int k = 0; k < 2; k++) begin
      fork
        monitor(1'b0, 1500, bits, nb, drv, viol, pb);
        pulse_a();
      join
      chk_cnt++; if (nb != 64) $display("FAIL b2b_nbits[%0d]: got %0d want 64", k, nb); else pass_cnt++;
      chk_cnt++; if (bits !== EXP_A) $display("FAIL b2b_bits[%0d]: got %h want %h", k, bits, EXP_A); else pass_cnt++;
      chk_cnt++; if (drv != 64 * PERIOD) $display("FAIL b2b_drive_len[%0d]: got %0d want %0d", k, drv, 64 * PERIOD); else pass_cnt++;
      chk_cnt++; if (viol != 0) $display("FAIL b2b_timing[%0d]: got %0d want 0", k, viol); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits; int nb, drv, viol, pb;
    bit c, d, v, pc, found;
    pulse_a();
    tick(700);
    sample(1'b0, c, d, v);
    chk_cnt++; if (d !== 1'b1) $display("FAIL midframe_driven: driven=%0b want 1", d); else pass_cnt++;
    found = 1'b0; pc = mdc_au;
    for (int i = 0; i < 4 * MDC_DIV && !found; i++) begin
      @(negedge sys_clk);
      if (mdc_au && !pc) found = 1'b1;
      pc = mdc_au;
    end
    chk_cnt++; if (!found) $display("FAIL midframe_rise_wait: got timeout want mdc rise"); else pass_cnt++;
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    sample(1'b0, c, d, v);
    chk_cnt++; if (c !== 1'b0) $display("FAIL abort_mdc: got %0b want 0", c); else pass_cnt++;
    chk_cnt++; if (d !== 1'b0) $display("FAIL abort_mdio_z: driven=%0b want 0", d); else pass_cnt++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    monitor(1'b0, 2000, bits, nb, drv, viol, pb);
    chk_cnt++; if (drv != 0) $display("FAIL abort_no_resume: got %0d driven cycles want 0", drv); else pass_cnt++;
    chk_cnt++; if (pb != 0) $display("FAIL abort_mdc_period: got %0d bad periods want 0", pb); else pass_cnt++;
  endtask

  task automatic test_params();
    logic [63:0] bits; int nb, drv, viol, pb;
    fork
      monitor(1'b1, 1400, bits, nb, drv, viol, pb);
      begin
        start_b = 1'b1; tick(1); start_b = 1'b0;
      end
    join
    chk_cnt++; if (nb != 64) $display("FAIL param_nbits: got %0d want 64", nb); else pass_cnt++;
    chk_cnt++; if (bits !== EXP_B) $display("FAIL param_bits: got %h want %h", bits, EXP_B); else pass_cnt++;
    chk_cnt++; if (drv != 64 * PERIOD) $display("FAIL param_drive_len: got %0d want %0d", drv, 64 * PERIOD); else pass_cnt++;
    chk_cnt++; if (viol != 0) $display("FAIL param_timing: got %0d want 0", viol); else pass_cnt++;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    test_reset();
    test_frame();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid_frame();
    test_params();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
